// File: rtl/sfx_sequencer.sv
// sfx_sequencer: arbitrates four sound-effect requests, walks a fixed note
// table for the winning effect and drives the square-wave tone generator and
// the audio amplifier control pins.
module sfx_sequencer #(
    parameter int TICK_DIV = 100000,  // system clocks per duration tick, >= 2
    parameter int MIN_HP   = 1000     // lower clamp for half_period while sweeping
) (
    input  logic        Clk_in,
    input  logic        Rst_n,
    input  logic [3:0]  req,
    input  logic        mute,
    input  logic        gain_sel,
    output logic [20:0] half_period,
    output logic        tone_en,
    output logic        gain,
    output logic        shutdown,
    output logic        busy,
    output logic [1:0]  active_id,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY
    } state_t;

    // One note step: tone half-period, length in ticks, signed sweep per tick,
    // and whether it is the final step of its effect.
    typedef struct packed {
        logic [20:0] hp;
        logic [8:0]  dur;
        logic [11:0] sweep;
        logic        last;
    } note_t;

    localparam int                 PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [20:0]        HP_MIN     = 21'(MIN_HP);
    localparam logic [20:0]        HP_MAX     = 21'h1F_FFFF;
    localparam logic signed [22:0] HP_MIN_S   = 23'(MIN_HP);
    localparam logic signed [22:0] HP_MAX_S   = 23'sd2097151;

    // Fixed effect table indexed by effect id and step number.
    function automatic note_t note_lookup(input logic [1:0] id, input logic [1:0] stp);
        note_t n;
        case ({id, stp})
            4'b00_00: n = '{21'd113636, 9'd40,  12'd0,   1'b0};
            4'b00_01: n = '{21'd56818,  9'd40,  12'd0,   1'b1};
            4'b01_00: n = '{21'd50000,  9'd300, 12'd200, 1'b1};
            4'b10_00: n = '{21'd200000, 9'd100, 12'd500, 1'b0};
            4'b10_01: n = '{21'd250000, 9'd200, 12'd500, 1'b1};
            4'b11_00: n = '{21'd113636, 9'd150, 12'd0,   1'b0};
            4'b11_01: n = '{21'd127551, 9'd150, 12'd0,   1'b0};
            4'b11_10: n = '{21'd143172, 9'd150, 12'd0,   1'b0};
            4'b11_11: n = '{21'd170262, 9'd300, 12'd0,   1'b1};
            default:  n = '{21'd0,      9'd1,   12'd0,   1'b1};
        endcase
        return n;
    endfunction

    // Highest-index pending request wins.
    function automatic logic [1:0] hi_index(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    state_t              state, state_d;
    logic [3:0]          pending, pending_d, clr_mask;
    logic [1:0]          step, load_id, load_step, hi_idx;
    logic [8:0]          remaining;
    logic [11:0]         sweep;
    logic                step_last;
    logic [PW-1:0]       presc;
    logic                tick, step_end, preempt, load_go, done_d, tone_en_d;
    logic signed [22:0]  hp_sum;
    logic [20:0]         hp_swept;
    note_t               note;

    assign note     = note_lookup(active_id, step);
    assign hi_idx   = hi_index(pending);
    assign tick     = (presc == PRESC_LAST);
    assign step_end = tick && (remaining == 9'd1);
    assign preempt  = (|pending) && (hi_idx > active_id);
    assign busy     = (state != S_IDLE);

    // Sweep the current half-period by one tick's worth, clamped to the legal range.
    always_comb begin
        hp_sum   = $signed({2'b00, half_period}) + $signed({{11{sweep[11]}}, sweep});
        hp_swept = hp_sum[20:0];
        if (hp_sum < HP_MIN_S)      hp_swept = HP_MIN;
        else if (hp_sum > HP_MAX_S) hp_swept = HP_MAX;
    end

    // State register.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state decision: pick the effect/step to load, end of effect, preemption.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a value unassigned and no latch is inferred.
        state_d   = state;
        load_go   = 1'b0;
        load_id   = active_id;
        load_step = step;
        done_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    state_d   = S_LOAD;
                    load_go   = 1'b1;
                    load_id   = hi_idx;
                    load_step = 2'd0;
                end
            end
            S_LOAD: state_d = S_PLAY;
            S_PLAY: begin
                if (step_end && step_last) begin
                    done_d = 1'b1;
                    if (|pending) begin
                        state_d   = S_LOAD;
                        load_go   = 1'b1;
                        load_id   = hi_idx;
                        load_step = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (preempt) begin
                    // Aborted effect is dropped: no done pulse, no re-queue.
                    state_d   = S_LOAD;
                    load_go   = 1'b1;
                    load_id   = hi_idx;
                    load_step = 2'd0;
                end else if (step_end) begin
                    state_d   = S_LOAD;
                    load_go   = 1'b1;
                    load_step = step + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending bookkeeping and tone enable: a new request beats a same-edge clear;
    // the tone stays on across any LOAD that is not entered from IDLE.
    always_comb begin
        clr_mask  = (load_go && load_step == 2'd0) ? (4'b0001 << load_id) : 4'b0000;
        pending_d = (pending & ~clr_mask) | req;
        tone_en_d = (state != S_IDLE) && (state_d != S_IDLE);
    end

    // Datapath: pending set, step/effect latch, prescaler, duration and sweep, amp pins.
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            pending     <= '0;
            active_id   <= '0;
            step        <= '0;
            half_period <= '0;
            remaining   <= '0;
            sweep       <= '0;
            step_last   <= 1'b0;
            presc       <= '0;
            tone_en     <= 1'b0;
            done        <= 1'b0;
            shutdown    <= 1'b0;
            gain        <= 1'b0;
        end else begin
            pending  <= pending_d;
            tone_en  <= tone_en_d;
            done     <= done_d;
            shutdown <= busy & ~mute;
            gain     <= gain_sel;
            if (load_go) begin
                active_id <= load_id;
                step      <= load_step;
            end
            if (state == S_LOAD) begin
                half_period <= note.hp;
                remaining   <= note.dur;
                sweep       <= note.sweep;
                step_last   <= note.last;
                presc       <= '0;
            end else if (state == S_PLAY) begin
                if (tick) begin
                    presc     <= '0;
                    remaining <= remaining - 9'd1;
                    if (!step_end) half_period <= hp_swept;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: expected per-cycle outputs are built from the note
// table with closed-form sweep arithmetic and compared every cycle.
module tb_sfx_sequencer;

    localparam int TD     = 10;
    localparam int MIN_HP = 1000;

    logic        Clk_in, Rst_n;
    logic [3:0]  req;
    logic        mute, gain_sel;
    logic [20:0] half_period;
    logic        tone_en, gain, shutdown, busy, done;
    logic [1:0]  active_id;

    sfx_sequencer #(.TICK_DIV(TD), .MIN_HP(MIN_HP)) dut (
        .Clk_in(Clk_in), .Rst_n(Rst_n), .req(req), .mute(mute), .gain_sel(gain_sel),
        .half_period(half_period), .tone_en(tone_en), .gain(gain), .shutdown(shutdown),
        .busy(busy), .active_id(active_id), .done(done)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    // Effect table as written in the datasheet.
    int n_steps [4]    = '{2, 1, 2, 4};
    int hp_tab  [4][4] = '{'{113636, 56818, 0, 0}, '{50000, 0, 0, 0},
                           '{200000, 250000, 0, 0}, '{113636, 127551, 143172, 170262}};
    int dur_tab [4][4] = '{'{40, 40, 0, 0}, '{300, 0, 0, 0}, '{100, 200, 0, 0}, '{150, 150, 150, 300}};
    int sw_tab  [4][4] = '{'{0, 0, 0, 0}, '{200, 0, 0, 0}, '{500, 500, 0, 0}, '{0, 0, 0, 0}};

    typedef struct {
        bit        busy;
        bit        tone;
        bit [1:0]  id;
        bit        done;
        bit [20:0] hp;
    } exp_t;

    exp_t      exp_q[$];
    bit [1:0]  g_id;
    bit [20:0] g_hp;
    bit        g_done;
    bit        last_gain, last_mute, p_busy, mute_rand;
    int        n_checks, n_fail;

    function automatic void push_exp(bit b, bit t, bit [1:0] id, bit [20:0] hp);
        exp_t e;
        e.busy = b; e.tone = t; e.id = id; e.done = g_done; e.hp = hp;
        g_done = 1'b0;
        exp_q.push_back(e);
    endfunction

    function automatic bit [20:0] swept(int hp0, int k, int sw);
        int v;
        v = hp0 + k * sw;
        if (v < MIN_HP)  v = MIN_HP;
        if (v > 2097151) v = 2097151;
        return 21'(v);
    endfunction

    function automatic void gen_idle(int n);
        for (int i = 0; i < n; i++) push_exp(1'b0, 1'b0, g_id, g_hp);
    endfunction

    // Append one effect: a LOAD sample per step, then dur*TD PLAY samples.
    // cut > 0 stops after that many PLAY samples of step 0 (preempted).
    function automatic void gen_effect(bit [1:0] id, bit first, int cut);
        g_id = id;
        for (int s = 0; s < n_steps[id]; s++) begin
            push_exp(1'b1, !(first && s == 0), id, g_hp);
            for (int c = 0; c < dur_tab[id][s] * TD; c++) begin
                if (cut > 0 && s == 0 && c == cut) return;
                g_hp = swept(hp_tab[id][s], c / TD, sw_tab[id][s]);
                push_exp(1'b1, 1'b1, id, g_hp);
            end
        end
        g_done = 1'b1;
    endfunction

    function automatic logic [27:0] obs_vec();
        return {busy, tone_en, active_id, done, gain, shutdown, half_period};
    endfunction

    function automatic logic [27:0] want_vec(int k);
        return {exp_q[k].busy, exp_q[k].tone, exp_q[k].id, exp_q[k].done,
                last_gain, p_busy & ~last_mute, exp_q[k].hp};
    endfunction

    // Drive random gain_sel (and mute when enabled), advance one clock, sample at negedge.
    task automatic step_cycle();
        gain_sel = 1'($urandom);
        if (mute_rand && $urandom_range(0, 7) == 0) mute = ~mute;
        last_gain = gain_sel;
        last_mute = mute;
        @(posedge Clk_in);
        @(negedge Clk_in);
        req = 4'b0000;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; req = '0; mute = 1'b0; gain_sel = 1'b0; mute_rand = 1'b0;
        repeat (2) @(negedge Clk_in);
        Rst_n = 1'b1;
        @(negedge Clk_in);
        g_id = '0; g_hp = '0; g_done = 1'b0; p_busy = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        gain_sel = 1'b1;
        #1;
        n_checks++; if (half_period !== 21'd0) begin n_fail++; $display("FAIL reset half_period: got %0d want 0", half_period); end
        n_checks++; if (tone_en !== 1'b0)      begin n_fail++; $display("FAIL reset tone_en: got %b want 0", tone_en); end
        n_checks++; if (shutdown !== 1'b0)     begin n_fail++; $display("FAIL reset shutdown: got %b want 0", shutdown); end
        n_checks++; if (gain !== 1'b0)         begin n_fail++; $display("FAIL reset gain: got %b want 0", gain); end
        n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (active_id !== 2'd0)    begin n_fail++; $display("FAIL reset active_id: got %0d want 0", active_id); end
        n_checks++; if (done !== 1'b0)         begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
        do_reset();
    endtask

    task automatic test_single();
        int gap;
        do_reset();
        gap = $urandom_range(0, 5);
        gen_idle(gap + 1); gen_effect(2'd0, 1'b1, 0); gen_idle(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == gap) req = 4'b0001;
            step_cycle();
            n_checks++;
            if (obs_vec() !== want_vec(k)) begin
                n_fail++; $display("FAIL single cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
            end
            p_busy = exp_q[k].busy;
        end
    endtask

    task automatic test_sweep();
        int gap;
        logic [20:0] prev_hp;
        do_reset();
        gap = $urandom_range(0, 5);
        prev_hp = '0;
        gen_idle(gap + 1); gen_effect(2'd1, 1'b1, 0); gen_idle(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == gap) req = 4'b0010;
            step_cycle();
            n_checks++;
            if (obs_vec() !== want_vec(k)) begin
                n_fail++; $display("FAIL sweep cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
            end
            if (exp_q[k].done) begin
                n_checks++;
                if (prev_hp !== 21'd109800) begin
                    n_fail++; $display("FAIL sweep final half_period: got %0d want 109800", prev_hp);
                end
            end
            prev_hp = half_period;
            p_busy = exp_q[k].busy;
        end
    endtask

    task automatic test_preempt();
        int gap, cut, inj_k;
        do_reset();
        gap = $urandom_range(0, 5);
        cut = $urandom_range(1, 399);
        gen_idle(gap + 1); gen_effect(2'd0, 1'b1, cut);
        inj_k = exp_q.size() - 1;
        gen_effect(2'd3, 1'b0, 0); gen_idle(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == gap)   req = 4'b0001;
            if (k == inj_k) req = 4'b1000;
            step_cycle();
            n_checks++;
            if (obs_vec() !== want_vec(k)) begin
                n_fail++; $display("FAIL preempt cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
            end
            p_busy = exp_q[k].busy;
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        do_reset();
        gap = $urandom_range(0, 5);
        gen_idle(gap + 1); gen_effect(2'd1, 1'b1, 0); gen_effect(2'd0, 1'b0, 0); gen_idle(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == gap) req = 4'b0011;
            step_cycle();
            n_checks++;
            if (obs_vec() !== want_vec(k)) begin
                n_fail++; $display("FAIL queue cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
            end
            p_busy = exp_q[k].busy;
        end
    endtask

    // Re-request of the active effect replays it; first pass hits the edge where
    // the bit is cleared by the load, second pass a random point in the effect.
    task automatic test_replay();
        int gap, inj_k;
        for (int it = 0; it < 2; it++) begin
            do_reset();
            gap = $urandom_range(0, 5);
            gen_idle(gap + 1); gen_effect(2'd0, 1'b1, 0);
            inj_k = (it == 0) ? gap + 1 : $urandom_range(gap + 1, exp_q.size() - 1);
            gen_effect(2'd0, 1'b0, 0); gen_idle(2);
            for (int k = 0; k < exp_q.size(); k++) begin
                if (k == gap)   req = 4'b0001;
                if (k == inj_k) req = 4'b0001;
                step_cycle();
                n_checks++;
                if (obs_vec() !== want_vec(k)) begin
                    n_fail++; $display("FAIL replay cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
                end
                p_busy = exp_q[k].busy;
            end
        end
    endtask

    task automatic test_mute();
        int gap;
        do_reset();
        mute_rand = 1'b1;
        gap = $urandom_range(0, 5);
        gen_idle(gap + 1); gen_effect(2'd2, 1'b1, 0); gen_idle(2);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == gap) req = 4'b0100;
            step_cycle();
            n_checks++;
            if (obs_vec() !== want_vec(k)) begin
                n_fail++; $display("FAIL mute cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
            end
            p_busy = exp_q[k].busy;
        end
        mute_rand = 1'b0;
        mute = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] pat;
        int         gap;
        bit         first;
        for (int it = 0; it < 2; it++) begin
            do_reset();
            mute_rand = 1'b1;
            pat = 4'($urandom_range(1, 15));
            gap = $urandom_range(0, 5);
            first = 1'b1;
            gen_idle(gap + 1);
            for (int id = 3; id >= 0; id--) begin
                if (pat[id]) begin gen_effect(2'(id), first, 0); first = 1'b0; end
            end
            gen_idle(2);
            for (int k = 0; k < exp_q.size(); k++) begin
                if (k == gap) req = pat;
                step_cycle();
                n_checks++;
                if (obs_vec() !== want_vec(k)) begin
                    n_fail++; $display("FAIL random pat %b cycle %0d: got %h want %h", pat, k, obs_vec(), want_vec(k)); break;
                end
                p_busy = exp_q[k].busy;
            end
            mute_rand = 1'b0;
            mute = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int gap, k_stop;
        do_reset();
        gap = $urandom_range(0, 5);
        k_stop = $urandom_range(gap + 20, gap + 3000);
        gen_idle(gap + 1); gen_effect(2'd3, 1'b1, 0);
        for (int k = 0; k <= k_stop; k++) begin
            if (k == gap)      req = 4'b1000;
            if (k == gap + 10) req = 4'b0001;
            step_cycle();
            n_checks++;
            if (obs_vec() !== want_vec(k)) begin
                n_fail++; $display("FAIL reset_mid cycle %0d: got %h want %h", k, obs_vec(), want_vec(k)); break;
            end
            p_busy = exp_q[k].busy;
        end
        #2 Rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_vec() !== 28'd0) begin
            n_fail++; $display("FAIL reset_mid async outputs: got %h want 0000000", obs_vec());
        end
        @(negedge Clk_in);
        gain_sel = 1'b0;
        mute = 1'b0;
        Rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge Clk_in);
            @(negedge Clk_in);
            n_checks++;
            if (obs_vec() !== 28'd0) begin
                n_fail++; $display("FAIL reset_mid idle cycle %0d: got %h want 0000000", k, obs_vec()); break;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        Rst_n = 1'b0; req = '0; mute = 1'b0; gain_sel = 1'b0; mute_rand = 1'b0;
        test_reset();
        test_single();
        test_sweep();
        test_preempt();
        test_back_to_back();
        test_replay();
        test_mute();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
